// File: rtl/oled_page_sched.sv
// Page-refresh scheduler: picks dirty OLED pages round-robin and streams 128 bytes
// per page from frame memory into the byte writer over a start/done handshake.
module oled_page_sched #(
  parameter logic [7:0]  INIT_DIRTY = 8'hFF,
  parameter logic [15:0] TIMEOUT    = 16'd4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        dirty_set,
  input  logic [2:0]  dirty_page,
  input  logic        refresh_all,
  output logic [9:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        disp_start,
  output logic [7:0]  disp_pos,
  output logic [7:0]  disp_data,
  output logic        disp_seq,
  input  logic        disp_done,
  output logic        busy,
  output logic        page_done,
  output logic        error,
  output logic [7:0]  dirty
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t      state;
  logic [2:0]  cur_page;
  logic [2:0]  last_page;
  logic [6:0]  col;
  logic [7:0]  data_q;
  logic [15:0] tmo_cnt;

  logic        pick_valid;
  logic [2:0]  pick_page;
  logic        start_page;
  logic        tmo_hit;
  logic [7:0]  set_mask;
  logic [7:0]  clr_mask;
  logic [7:0]  dirty_next;

  // Round-robin search starting just above the last served page; i = 8 wraps to last_page.
  always_comb begin
    // NOTE: every combinational output is given a default first so no latch is inferred.
    pick_valid = 1'b0;
    pick_page  = last_page;
    for (int i = 1; i <= 8; i++) begin
      if (!pick_valid && dirty[last_page + 3'(i)]) begin
        pick_valid = 1'b1;
        pick_page  = last_page + 3'(i);
      end
    end
  end

  always_comb begin
    start_page = (state == ST_IDLE) && en && pick_valid;
    tmo_hit    = (state == ST_WAIT) && !disp_done && ((tmo_cnt + 16'd1) == TIMEOUT);
    set_mask   = (dirty_set   ? (8'd1 << dirty_page) : 8'd0)
               | (refresh_all ? 8'hFF                : 8'd0)
               | (tmo_hit     ? (8'd1 << cur_page)   : 8'd0);
    clr_mask   = start_page ? (8'd1 << pick_page) : 8'd0;
    // Set is applied after clear so a re-mark during the pick cycle is never lost.
    dirty_next = (dirty & ~clr_mask) | set_mask;
  end

  // Byte data is held in data_q from capture until the next capture, covering the handshake.
  assign disp_data = data_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      dirty      <= INIT_DIRTY;
      cur_page   <= 3'd0;
      last_page  <= 3'd7;
      col        <= 7'd0;
      data_q     <= 8'd0;
      tmo_cnt    <= 16'd0;
      mem_addr   <= 10'd0;
      disp_start <= 1'b0;
      disp_pos   <= 8'd0;
      disp_seq   <= 1'b0;
      busy       <= 1'b0;
      page_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      dirty      <= dirty_next;
      disp_start <= 1'b0;
      page_done  <= 1'b0;
      error      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_page) begin
            cur_page <= pick_page;
            col      <= 7'd0;
            mem_addr <= {pick_page, 7'd0};
            busy     <= 1'b1;
            state    <= ST_RD;
          end
        end
        ST_RD: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          data_q     <= mem_rdata;
          disp_pos   <= {4'd0, 1'b0, cur_page};
          disp_seq   <= (col != 7'd0);
          disp_start <= 1'b1;
          state      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          tmo_cnt <= 16'd0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (disp_done) begin
            if (col == 7'd127) begin
              page_done <= 1'b1;
              last_page <= cur_page;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              col      <= col + 7'd1;
              mem_addr <= {cur_page, col + 7'd1};
              state    <= ST_RD;
            end
          end else if (tmo_hit) begin
            error     <= 1'b1;
            last_page <= cur_page;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_page_sched.sv
// Directed bench for oled_page_sched: frame-memory and byte-writer models plus
// a negedge monitor that logs every handshake event for later checking.
module tb_oled_page_sched;

  localparam logic [7:0]  INIT_DIRTY = 8'hFF;
  localparam logic [15:0] TIMEOUT    = 16'd16;
  localparam int          WR_LAT     = 5;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dirty_set;
  logic [2:0] dirty_page;
  logic       refresh_all;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       disp_start;
  logic [7:0] disp_pos;
  logic [7:0] disp_data;
  logic       disp_seq;
  logic       disp_done;
  logic       busy;
  logic       page_done;
  logic       error;
  logic [7:0] dirty;

  oled_page_sched #(
    .INIT_DIRTY (INIT_DIRTY),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .dirty_set   (dirty_set),
    .dirty_page  (dirty_page),
    .refresh_all (refresh_all),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .disp_start  (disp_start),
    .disp_pos    (disp_pos),
    .disp_data   (disp_data),
    .disp_seq    (disp_seq),
    .disp_done   (disp_done),
    .busy        (busy),
    .page_done   (page_done),
    .error       (error),
    .dirty       (dirty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  typedef struct {
    int         cyc;
    logic [7:0] pos;
    logic       seq;
    logic [7:0] data;
    logic [9:0] addr;
  } issue_t;

  issue_t     issues[$];
  int         pdone_cyc[$];
  logic [2:0] pdone_page[$];
  logic       pdone_busy[$];
  int         err_cyc[$];
  logic [7:0] err_dirty[$];
  int         n_done_pulses;
  bit         writer_mute;

  function automatic logic [7:0] mem_byte(input logic [9:0] a);
    return a[7:0] ^ {a[9:7], 5'b10101};
  endfunction

  // Memory returns data one cycle after the address; writer answers WR_LAT cycles after start.
  initial begin
    int         wr_cnt;
    logic [9:0] addr_q;
    issue_t     e;
    wr_cnt        = 0;
    addr_q        = 10'd0;
    n_done_pulses = 0;
    disp_done     = 1'b0;
    mem_rdata     = 8'd0;
    forever begin
      @(negedge clk);
      mem_rdata = mem_byte(addr_q);
      addr_q    = mem_addr;
      disp_done = 1'b0;
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) begin
          disp_done = 1'b1;
          n_done_pulses++;
        end
      end
      if (disp_start === 1'b1) begin
        e.cyc  = cyc;
        e.pos  = disp_pos;
        e.seq  = disp_seq;
        e.data = disp_data;
        e.addr = mem_addr;
        issues.push_back(e);
        if (!writer_mute) wr_cnt = WR_LAT;
      end
      if (page_done === 1'b1) begin
        pdone_cyc.push_back(cyc);
        pdone_page.push_back(disp_pos[2:0]);
        pdone_busy.push_back(busy);
      end
      if (error === 1'b1) begin
        err_cyc.push_back(cyc);
        err_dirty.push_back(dirty);
      end
    end
  end

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares a run of logged byte writes against the page/column order they must follow.
  task automatic scan(input string tag, input int b, input int cnt, input logic [2:0] pg0);
    int         bp, bs, ba, bd;
    logic [2:0] pg;
    logic [6:0] c;
    logic [9:0] ea;
    issue_t     e;
    bp = 0; bs = 0; ba = 0; bd = 0;
    for (int i = 0; i < cnt; i++) begin
      pg = pg0 + 3'(i / 128);
      c  = 7'(i % 128);
      ea = {pg, c};
      if (b + i >= issues.size()) begin
        bp++;
      end else begin
        e = issues[b + i];
        if (e.pos !== {5'd0, pg}) bp++;
        if (e.seq !== (c != 7'd0)) bs++;
        if (e.addr !== ea) ba++;
        if (e.data !== mem_byte(ea)) bd++;
      end
    end
    check({tag, "_pos"}, bp, 0);
    check({tag, "_seq"}, bs, 0);
    check({tag, "_addr"}, ba, 0);
    check({tag, "_data"}, bd, 0);
  endtask

  initial begin
    int  t, base, pbase, ebase, n0, s0, dn0, ib, pd0, er0, bad;
    bit  d3_drop;
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    en          = 1'b0;
    dirty_set   = 1'b0;
    dirty_page  = 3'd0;
    refresh_all = 1'b0;
    writer_mute = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_dirty", dirty, 8'hFF);
    check("rst_busy", busy, 0);
    check("rst_pulses", {disp_start, disp_seq, page_done, error}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_disp_pos", disp_pos, 0);
    check("rst_disp_data", disp_data, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("en_low_idle", busy, 0);
    check("en_low_no_start", issues.size(), 0);

    // Full-screen refresh from INIT_DIRTY
    base  = issues.size();
    pbase = pdone_cyc.size();
    en    = 1'b1;
    t = 0;
    while (pdone_cyc.size() < pbase + 8 && t < 12000) begin @(negedge clk); t++; end
    check("full_in_time", t < 12000, 1);
    check("full_starts", issues.size() - base, 1024);
    scan("full", base, 1024, 3'd0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (pbase + k >= pdone_page.size()) bad++;
      else if (pdone_page[pbase + k] !== 3'(k) || pdone_busy[pbase + k] !== 1'b0) bad++;
    end
    check("full_page_done_order", bad, 0);
    check("full_dirty_clear", dirty, 8'h00);
    check("full_no_error", err_cyc.size(), 0);

    // Single page from idle: latency and address stream
    repeat (5) @(negedge clk);
    base       = issues.size();
    pbase      = pdone_cyc.size();
    dirty_set  = 1'b1;
    dirty_page = 3'd5;
    n0         = cyc;
    @(negedge clk);
    dirty_set = 1'b0;
    check("p5_visible", dirty, 8'h20);
    @(negedge clk);
    check("p5_rd_addr", mem_addr, 10'h280);
    check("p5_busy", busy, 1);
    check("p5_cleared", dirty, 8'h00);
    t = 0;
    while (pdone_cyc.size() < pbase + 1 && t < 2000) begin @(negedge clk); t++; end
    check("p5_in_time", t < 2000, 1);
    check("p5_starts", issues.size() - base, 128);
    scan("p5", base, 128, 3'd5);
    if (issues.size() >= base + 128) begin
      check("p5_first_latency", issues[base].cyc - n0, 4);
      check("p5_byte_period", issues[base + 1].cyc - issues[base].cyc, WR_LAT + 3);
      check("p5_page_done_cycle", pdone_cyc[pbase] - issues[base + 127].cyc, WR_LAT + 1);
    end

    // Page re-marked during its own refresh, with another page pending
    base       = issues.size();
    pbase      = pdone_cyc.size();
    dirty_set  = 1'b1;
    dirty_page = 3'd3;
    @(negedge clk);
    dirty_set = 1'b0;
    repeat (20) @(negedge clk);
    check("rd_busy_p3", busy, 1);
    dirty_set  = 1'b1;
    dirty_page = 3'd3;
    @(negedge clk);
    dirty_page = 3'd1;
    @(negedge clk);
    dirty_set = 1'b0;
    check("rd_mask", dirty, 8'h0A);
    d3_drop = 1'b0;
    t = 0;
    while (pdone_cyc.size() < pbase + 3 && t < 4000) begin
      @(negedge clk);
      t++;
      if (pdone_cyc.size() < pbase + 2 && dirty[3] !== 1'b1) d3_drop = 1'b1;
    end
    check("rd_in_time", t < 4000, 1);
    check("rd_dirty3_held", d3_drop, 0);
    if (pdone_page.size() >= pbase + 3)
      check("rd_order", {pdone_page[pbase], pdone_page[pbase + 1], pdone_page[pbase + 2]},
            {3'd3, 3'd1, 3'd3});
    check("rd_starts", issues.size() - base, 384);

    // en dropped mid-page
    base        = issues.size();
    pbase       = pdone_cyc.size();
    refresh_all = 1'b1;
    @(negedge clk);
    refresh_all = 1'b0;
    check("en_refresh_all", dirty, 8'hFF);
    t = 0;
    while (issues.size() < base + 10 && t < 200) begin @(negedge clk); t++; end
    en = 1'b0;
    t = 0;
    while (pdone_cyc.size() < pbase + 1 && t < 2000) begin @(negedge clk); t++; end
    check("en_page_in_time", t < 2000, 1);
    repeat (30) @(negedge clk);
    check("en_page_bytes", issues.size() - base, 128);
    bad = 0;
    for (int i = base; i < issues.size(); i++) if (issues[i].pos !== 8'h04) bad++;
    check("en_page_is_4", bad, 0);
    check("en_stopped_busy", busy, 0);
    check("en_stopped_dirty", dirty, 8'hEF);
    base = issues.size();
    en   = 1'b1;
    n0   = cyc;
    t = 0;
    while (issues.size() <= base && t < 20) begin @(negedge clk); t++; end
    check("en_resume_seen", t < 20, 1);
    s0 = n0;
    if (issues.size() > base) begin
      check("en_resume_latency", issues[base].cyc - n0, 3);
      check("en_resume_pos", issues[base].pos, 8'h05);
      s0 = issues[base].cyc;
    end

    // Reset while waiting for disp_done, then a stale done arrives
    while (cyc < s0 + 1) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    dn0 = n_done_pulses;
    ib  = issues.size();
    pd0 = pdone_cyc.size();
    er0 = err_cyc.size();
    @(negedge clk);
    rst = 1'b0;
    check("wrst_busy", busy, 0);
    check("wrst_dirty", dirty, INIT_DIRTY);
    check("wrst_no_pulses", {page_done, error}, 0);
    repeat (10) @(negedge clk);
    check("wrst_stale_done_sent", n_done_pulses > dn0, 1);
    check("wrst_no_start", issues.size() - ib, 0);
    check("wrst_no_page_done", pdone_cyc.size() - pd0, 0);
    check("wrst_no_error", err_cyc.size() - er0, 0);
    check("wrst_idle", busy, 0);

    // Writer never answers: timeout path
    writer_mute = 1'b1;
    base  = issues.size();
    ebase = err_cyc.size();
    en    = 1'b1;
    t = 0;
    while (err_cyc.size() < ebase + 2 && t < 200) begin @(negedge clk); t++; end
    check("tmo_in_time", t < 200, 1);
    if (err_cyc.size() >= ebase + 2 && issues.size() >= base + 2) begin
      check("tmo_first_pos", issues[base].pos, 8'h00);
      check("tmo_error_delay", err_cyc[ebase] - issues[base].cyc, 17);
      check("tmo_dirty_reset", err_dirty[ebase], 8'hFF);
      check("tmo_next_pos", issues[base + 1].pos, 8'h01);
      check("tmo_next_start", issues[base + 1].cyc - issues[base].cyc, 20);
      check("tmo_second_error", err_cyc[ebase + 1] - issues[base + 1].cyc, 17);
    end
    en = 1'b0;
    repeat (40) @(negedge clk);
    check("tmo_settled", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
